// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the 8N1 UART transceiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int DEF_CLK_FREQ = 27_000_000;
  localparam int DEF_BAUD     = 115_200;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 receiver with 2-flop input synchronizer and centre
//               sampling. UART_FRAME_ERR_EN adds the o_frame_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_ready
`ifdef UART_FRAME_ERR_EN
  ,
  output logic                 o_frame_err
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rxd_meta_q, rxd_sync_q;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 wait_high_q, wait_high_d;
  logic                 bit_done;

  assign bit_done = (cnt_q == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      rxd_meta_q  <= i_rxd;
      rxd_sync_q  <= rxd_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      wait_high_q <= wait_high_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    ready_d     = 1'b0;
    wait_high_d = wait_high_q;
    case (state_q)
      S_IDLE: begin
        cnt_d       = '0;
        idx_d       = '0;
        wait_high_d = 1'b0;
        if (!rxd_sync_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxd_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == C_IDX_LAST) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        // After a framing error the FSM parks here until the line is idle again.
        if (wait_high_q) begin
          if (rxd_sync_q) begin
            wait_high_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bit_done) begin
            cnt_d = '0;
            if (rxd_sync_q) begin
              data_d  = shift_q;
              ready_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              wait_high_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data  = data_q;
  assign o_ready = ready_q;

`ifdef UART_FRAME_ERR_EN
  logic frame_err_q;
  logic frame_err_d;

  assign frame_err_d = (state_q == S_STOP) && !wait_high_q && bit_done && !rxd_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign o_frame_err = frame_err_q;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : 8N1 transmitter; latches a byte in IDLE and shifts it out
//               LSB first with start and stop bits on a registered TXD.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_data_ready,
  output logic                 o_txd,
  output logic                 o_idle
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 idle_q, idle_d;
  logic                 bit_done;

  assign bit_done = (cnt_q == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      idle_q  <= idle_d;
    end
  end

  // TXD and TX_IDLE are computed one step ahead so both outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    idle_d  = idle_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        txd_d  = 1'b1;
        idle_d = 1'b1;
        if (i_data_ready) begin
          shift_d = i_data;
          txd_d   = 1'b0;
          idle_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_done) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == C_IDX_LAST) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          idle_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_txd  = txd_q;
  assign o_idle = idle_q;

endmodule
`default_nettype wire

// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_transceiver
// Description : Full-duplex 8N1 UART built from independent TX and RX cores.
//               Define UART_FRAME_ERR_EN to expose the RX_FRAME_ERR port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_DATA_READY,
  output logic                 TXD,
  output logic                 TX_IDLE,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RXD_READY
`ifdef UART_FRAME_ERR_EN
  ,
  output logic                 RX_FRAME_ERR
`endif
);

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk          (CLK),
    .rst          (RST),
    .i_data       (TX_DATA),
    .i_data_ready (TX_DATA_READY),
    .o_txd        (TXD),
    .o_idle       (TX_IDLE)
  );

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (CLK),
    .rst          (RST),
    .i_rxd        (RXD),
    .o_data       (RX_DATA),
    .o_ready      (RXD_READY)
`ifdef UART_FRAME_ERR_EN
    ,
    .o_frame_err  (RX_FRAME_ERR)
`endif
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transceiver
// Description : Scoreboard bench for uart_transceiver (loopback, waveform,
//               glitch and framing-error cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int CPB = 234;
  localparam int FRAME_CYCLES = 10 * CPB;
  localparam logic [9:0] WAVE_A5 = 10'b11_0100_1010;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       txd;
  logic       tx_idle;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rxd_ready;
  logic       loop_en;
  logic       rxd_drv;
`ifdef UART_FRAME_ERR_EN
  logic       rx_frame_err;
  int         frame_err_pulses = 0;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rx_pulses = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_transceiver dut (
    .CLK           (clk),
    .RST           (rst),
    .TX_DATA       (tx_data),
    .TX_DATA_READY (tx_ready),
    .TXD           (txd),
    .TX_IDLE       (tx_idle),
    .RXD           (rxd),
    .RX_DATA       (rx_data),
    .RXD_READY     (rxd_ready)
`ifdef UART_FRAME_ERR_EN
    ,
    .RX_FRAME_ERR  (rx_frame_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RXD_READY pulse consumes one expected byte.
  always @(negedge clk) begin
    if (!rst && rxd_ready === 1'b1) begin
      rx_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got RX_DATA=0x%0h, expected no RXD_READY", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
`ifdef UART_FRAME_ERR_EN
    if (!rst && rx_frame_err === 1'b1) frame_err_pulses++;
`endif
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input bit wave,
                           input logic [9:0] wexp);
    int low;
    int bad[10];
    bit done;
    foreach (bad[k]) bad[k] = 0;
    low  = 0;
    done = 1'b0;
    @(negedge clk);
    tx_data  = b;
    tx_ready = 1'b1;
    if (loop_en) exp_q.push_back(b);
    @(posedge clk);
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tx_data = 'x;
        check("tx_idle_fall", {31'd0, tx_idle}, 32'd0);
      end
      if (c == hold - 1) tx_ready = 1'b0;
      if (wave && c < FRAME_CYCLES && txd !== wexp[c / CPB]) bad[c / CPB]++;
      if (tx_idle === 1'b0) low++;
      else done = 1'b1;
    end
    tx_ready = 1'b0;
    check("tx_busy_cycles", low, FRAME_CYCLES);
    if (wave) begin
      for (int k = 0; k < 10; k++) check($sformatf("txd_bit%0d_errs", k), bad[k], 0);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd_drv = f[k];
      repeat (CPB) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 100000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int stream[15];
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_ready = 1'b0;
    loop_en  = 1'b1;
    rxd_drv  = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_txd",       {31'd0, txd},       32'd1);
    check("reset_tx_idle",   {31'd0, tx_idle},   32'd1);
    check("reset_rxd_ready", {31'd0, rxd_ready}, 32'd0);
    check("reset_rx_data",   {24'd0, rx_data},   32'd0);

    // Single 0x00 in loopback.
    p0 = rx_pulses;
    send_byte(8'h00, 2, 1'b0, 10'd0);
    repeat (5) @(negedge clk);
    check("single_rx_pulses", rx_pulses - p0, 1);
    check("single_queue_empty", exp_q.size(), 0);

    // Stream with wrap to 0x00; TX_DATA goes X after each latch.
    for (int i = 0; i < 12; i++) stream[i] = i + 1;
    stream[12] = 8'hFE;
    stream[13] = 8'hFF;
    stream[14] = 8'h00;
    p0 = rx_pulses;
    foreach (stream[i]) send_byte(stream[i][7:0], 50, 1'b0, 10'd0);
    repeat (5) @(negedge clk);
    check("stream_rx_pulses", rx_pulses - p0, 15);
    check("stream_queue_empty", exp_q.size(), 0);

    // Bit-accurate TXD waveform for 0xA5.
    p0 = rx_pulses;
    send_byte(8'hA5, 2, 1'b1, WAVE_A5);
    repeat (5) @(negedge clk);
    check("a5_rx_pulses", rx_pulses - p0, 1);

    // Short low glitch on RXD must not start a frame.
    loop_en = 1'b0;
    p0 = rx_pulses;
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (50) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_rx_pulses", rx_pulses - p0, 0);
    check("glitch_rx_state_idle", 32'(dut.u_rx.state_q), 32'(S_IDLE));

    // Framing error on 0x3C, then a clean 0x55.
    p0 = rx_pulses;
    drive_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_rx_pulses", rx_pulses - p0, 0);
    check("ferr_rx_data_kept", {24'd0, rx_data}, 32'h0000_00A5);
`ifdef UART_FRAME_ERR_EN
    check("ferr_pulses", frame_err_pulses, 1);
`endif
    p0 = rx_pulses;
    exp_q.push_back(8'h55);
    drive_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("after_ferr_rx_pulses", rx_pulses - p0, 1);
    check("after_ferr_rx_data", {24'd0, rx_data}, 32'h0000_0055);
    check("final_queue_empty", exp_q.size(), 0);
`ifdef UART_FRAME_ERR_EN
    check("ferr_pulses_final", frame_err_pulses, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
